// File: rtl/shift_pattern_ctrl_pkg.sv
// ============================================================================
// Module      : shift_pattern_ctrl_pkg
// Description : Mode encodings and default seed shared by the LED pattern stages
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pattern_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_SHL = 2'b00,
    MODE_SHR = 2'b01,
    MODE_ROL = 2'b10,
    MODE_BNC = 2'b11
  } mode_e;

  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

endpackage : shift_pattern_ctrl_pkg

`default_nettype wire

// File: rtl/shift_pattern_ctrl_rise_detect.sv
// ============================================================================
// Module      : rise_detect
// Description : Two-flop rising-edge detector; one-cycle pulse per rise of sig
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic pulse
);

  logic r_s1;
  logic r_s2;

  // Both stages reset high so a signal already high at reset release is not a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= sig;
      r_s2 <= r_s1;
    end
  end

  assign pulse = r_s1 & ~r_s2;

endmodule : rise_detect

`default_nettype wire

// File: rtl/shift_pattern_ctrl.sv
// ============================================================================
// Module      : shift_pattern_ctrl
// Description : LED pattern generator (shift/rotate/bounce) stepped by clk_1hz
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_pattern_ctrl
  import shift_pattern_ctrl_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_1hz,
  input  logic             run,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] led,
  output logic             dir,
  output logic             wrap
);

  logic             w_step;
  logic [WIDTH-1:0] r_led;
  logic             r_dir;
  logic             r_wrap;
  logic             r_in_bnc;
  logic [WIDTH-1:0] w_led_next;
  logic             w_dir_next;
  logic             w_wrap_next;
  logic             w_in_bnc_next;
  logic             w_dir_eff;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_shr;

  rise_detect u_rise_detect (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (clk_1hz),
    .pulse (w_step)
  );

  always_comb begin
    w_led_next    = r_led;
    w_dir_next    = r_dir;
    w_wrap_next   = 1'b0;
    w_in_bnc_next = r_in_bnc;
    w_shl         = r_led << 1;
    w_shr         = r_led >> 1;
    // A stale dir from an earlier bounce session is ignored on the first bounce step.
    w_dir_eff     = r_in_bnc & r_dir;

    if (load) begin
      w_led_next = load_data;
      w_dir_next = 1'b0;
    end else if (w_step && run) begin
      w_in_bnc_next = (mode == MODE_BNC);
      if (mode == MODE_BNC) begin
        w_dir_next = w_dir_eff;
      end
      if (r_led == '0) begin
        w_led_next  = SEED;
        w_wrap_next = 1'b1;
      end else begin
        case (mode)
          MODE_SHL: begin
            if (w_shl == '0) begin
              w_led_next  = SEED;
              w_wrap_next = 1'b1;
            end else begin
              w_led_next = w_shl;
            end
          end
          MODE_SHR: begin
            if (w_shr == '0) begin
              w_led_next  = SEED;
              w_wrap_next = 1'b1;
            end else begin
              w_led_next = w_shr;
            end
          end
          MODE_ROL: begin
            w_led_next  = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
            w_wrap_next = r_led[WIDTH-1];
          end
          default: begin
            if (!w_dir_eff) begin
              if (r_led[WIDTH-1]) begin
                w_dir_next  = 1'b1;
                w_led_next  = w_shr;
                w_wrap_next = 1'b1;
              end else begin
                w_led_next = w_shl;
              end
            end else begin
              if (r_led[0]) begin
                w_dir_next  = 1'b0;
                w_led_next  = w_shl;
                w_wrap_next = 1'b1;
              end else begin
                w_led_next = w_shr;
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led    <= SEED;
      r_dir    <= 1'b0;
      r_wrap   <= 1'b0;
      r_in_bnc <= 1'b0;
    end else begin
      r_led    <= w_led_next;
      r_dir    <= w_dir_next;
      r_wrap   <= w_wrap_next;
      r_in_bnc <= w_in_bnc_next;
    end
  end

  assign led  = r_led;
  assign dir  = r_dir;
  assign wrap = r_wrap;

endmodule : shift_pattern_ctrl

`default_nettype wire

// File: tb/tb_shift_pattern_ctrl.sv
// ============================================================================
// Module      : tb_shift_pattern_ctrl
// Description : Directed self-checking bench for shift_pattern_ctrl
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_pattern_ctrl;

  logic       clk;
  logic       rst_n;
  logic       clk_1hz;
  logic       run;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_data;
  logic [7:0] led;
  logic       dir;
  logic       wrap;

  int n_cmp;
  int n_err;

  shift_pattern_ctrl #(.WIDTH(8), .SEED(8'h01)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_1hz   (clk_1hz),
    .run       (run),
    .mode      (mode),
    .load      (load),
    .load_data (load_data),
    .led       (led),
    .dir       (dir),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One clk_1hz rise; led updates two edges later and wrap must last one cycle.
  task automatic do_step(input string tag, input logic [7:0] e_led,
                         input logic e_dir, input logic e_wrap);
    clk_1hz = 1'b1;
    tick(2);
    check({tag, ".led"}, led, e_led);
    check({tag, ".dir"}, dir, e_dir);
    check({tag, ".wrap"}, wrap, e_wrap);
    tick(1);
    check({tag, ".wrap_off"}, wrap, 1'b0);
    check({tag, ".led_hold"}, led, e_led);
    clk_1hz = 1'b0;
    tick(3);
  endtask

  task automatic do_load(input logic [7:0] d);
    load      = 1'b1;
    load_data = d;
    tick(1);
    load      = 1'b0;
    tick(1);
  endtask

  logic [7:0] bnc_led [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                               8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic       bnc_dir [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       bnc_wrp [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    clk_1hz   = 1'b0;
    run       = 1'b1;
    mode      = 2'b00;
    load      = 1'b0;
    load_data = 8'h00;
    tick(2);
    check("rst.led", led, 8'h01);
    check("rst.dir", dir, 1'b0);
    check("rst.wrap", wrap, 1'b0);
    rst_n = 1'b1;
    tick(2);

    // Shift-left: 02..80 then wrap back to seed
    for (int i = 1; i < 8; i++) begin
      do_step($sformatf("shl%0d", i), 8'(1 << i), 1'b0, 1'b0);
    end
    do_step("shl8", 8'h01, 1'b0, 1'b1);

    // Bounce: one full cycle plus the turn at the bottom
    mode = 2'b11;
    for (int i = 0; i < 15; i++) begin
      do_step($sformatf("bnc%0d", i), bnc_led[i], bnc_dir[i], bnc_wrp[i]);
    end
    // Climb to 80, turn, come down to 10 with dir=1
    for (int i = 2; i < 8; i++) begin
      do_step($sformatf("bnc_up%0d", i), 8'(1 << i), 1'b0, 1'b0);
    end
    do_step("bnc_turn", 8'h40, 1'b1, 1'b1);
    do_step("bnc_dn20", 8'h20, 1'b1, 1'b0);
    do_step("bnc_dn10", 8'h10, 1'b1, 1'b0);

    // Asynchronous reset with clk_1hz held high through release
    clk_1hz = 1'b1;
    rst_n   = 1'b0;
    #1;
    check("arst.led", led, 8'h01);
    check("arst.dir", dir, 1'b0);
    check("arst.wrap", wrap, 1'b0);
    tick(2);
    rst_n = 1'b1;
    mode  = 2'b00;
    tick(4);
    check("hi_rel.led", led, 8'h01);
    check("hi_rel.wrap", wrap, 1'b0);
    clk_1hz = 1'b0;
    tick(3);
    check("hi_rel.led2", led, 8'h01);
    do_step("fresh_rise", 8'h02, 1'b0, 1'b0);

    // run=0 holds across three rises
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_step($sformatf("hold%0d", i), 8'h02, 1'b0, 1'b0);
    end
    run = 1'b1;
    do_step("resume", 8'h04, 1'b0, 1'b0);

    // Load coincident with the step cycle wins; then rotate-left
    mode    = 2'b10;
    clk_1hz = 1'b1;
    tick(1);
    load      = 1'b1;
    load_data = 8'hA5;
    tick(1);
    load = 1'b0;
    check("ld.led", led, 8'hA5);
    check("ld.wrap", wrap, 1'b0);
    check("ld.dir", dir, 1'b0);
    tick(1);
    check("ld.led_hold", led, 8'hA5);
    clk_1hz = 1'b0;
    tick(3);
    do_step("rol1", 8'h4B, 1'b0, 1'b1);
    do_step("rol2", 8'h96, 1'b0, 1'b0);

    // Shift-right from seed wraps immediately
    mode = 2'b01;
    do_load(8'h01);
    check("ld01.led", led, 8'h01);
    do_step("shr_wrap", 8'h01, 1'b0, 1'b1);
    do_load(8'h80);
    do_step("shr80", 8'h40, 1'b0, 1'b0);

    // Zero pattern recovers in rotate mode
    mode = 2'b10;
    do_load(8'h00);
    check("ld00.led", led, 8'h00);
    do_step("zero", 8'h01, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_shift_pattern_ctrl

`default_nettype wire
